// File: rtl/elbeth_memory_bridge_pipe.sv
// Registered bridge between the Elbeth core's fetch/data ports and memory ports A (fetch) and B (load/store).
// Each port runs an IDLE -> BUSY -> DONE request tracker. Alignment and range faults are resolved in IDLE
// without touching memory. A hung memory is converted into an access fault after TIMEOUT wait cycles.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_*                             core fetch request/response (ready is a one-cycle strobe)
//   dmem_*                             core load/store request/response (ready is a one-cycle strobe)
//   amem_*                             fetch memory port (read only)
//   bmem_*                             load/store memory port with byte write enables
module elbeth_memory_bridge_pipe #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_en,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_in_data,
  output logic              imem_ready,
  output logic              imem_except,
  output logic [3:0]        imem_except_src,
  input  logic              dmem_en,
  input  logic              dmem_rw,
  input  logic [3:0]        dmem_data_inf,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_out_data,
  output logic [31:0]       dmem_in_data,
  output logic              dmem_ready,
  output logic              dmem_except,
  output logic [3:0]        dmem_except_src,
  output logic              amem_en,
  output logic [ADDR_W-1:0] amem_addr,
  input  logic [31:0]       amem_in_data,
  input  logic              amem_ready,
  input  logic              amem_error,
  output logic              bmem_en,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic [3:0]        bmem_rw,
  output logic [31:0]       bmem_out_data,
  input  logic [31:0]       bmem_in_data,
  input  logic              bmem_ready,
  input  logic              bmem_error
);

  localparam int unsigned HI_LSB = ADDR_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [3:0] ECODE_INST_ADDR_MISALIGNED      = 4'd0;
  localparam logic [3:0] ECODE_INST_ADDR_FAULT           = 4'd1;
  localparam logic [3:0] ECODE_LOAD_ADDR_MISALIGNED      = 4'd4;
  localparam logic [3:0] ECODE_LOAD_ACCESS_FAULT         = 4'd5;
  localparam logic [3:0] ECODE_STORE_AMO_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] ECODE_STORE_AMO_ACCESS_FAULT    = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  // Any address bit above the implemented memory selects nothing.
  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr >> HI_LSB) != 32'd0;
  endfunction

  // dmem_data_inf = {signed, word, half, byte}
  function automatic logic d_misaligned(input logic [3:0] inf, input logic [1:0] lo);
    return (inf[2] & (lo != 2'b00)) | (inf[1] & lo[0]);
  endfunction

  function automatic logic [3:0] store_we(input logic [3:0] inf, input logic [1:0] lo);
    if (inf[0])      return 4'b0001 << lo;
    else if (inf[1]) return lo[1] ? 4'b1100 : 4'b0011;
    else             return 4'b1111;
  endfunction

  // Replicate the store value across all lanes; the enables pick the active ones.
  function automatic logic [31:0] store_lanes(input logic [3:0] inf, input logic [31:0] d);
    if (inf[0])      return {4{d[7:0]}};
    else if (inf[1]) return {2{d[15:0]}};
    else             return d;
  endfunction

  // Shift the addressed lane down and extend per size/sign.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [3:0] inf);
    logic [31:0] sh;
    sh = w >> {lo, 3'b000};
    if (inf[0])      return {{24{inf[3] & sh[7]}}, sh[7:0]};
    else if (inf[1]) return {{16{inf[3] & sh[15]}}, sh[15:0]};
    else             return w;
  endfunction

  // ---------------- Port A: fetch ----------------
  state_e             a_state_q, a_state_d;
  logic [CNT_W-1:0]   a_cnt_q, a_cnt_d;
  logic               a_en_q, a_en_d;
  logic [ADDR_W-1:0]  a_addr_q, a_addr_d;
  logic [31:0]        i_data_q, i_data_d;
  logic               i_ready_q, i_ready_d;
  logic               i_exc_q, i_exc_d;
  logic [3:0]         i_src_q, i_src_d;

  // Fetch request tracker: next state and registered outputs.
  always_comb begin
    a_state_d = a_state_q;
    a_cnt_d   = '0;
    a_en_d    = 1'b0;
    a_addr_d  = a_addr_q;
    i_data_d  = '0;
    i_ready_d = 1'b0;
    i_exc_d   = 1'b0;
    i_src_d   = '0;
    unique case (a_state_q)
      S_IDLE: begin
        if (imem_en) begin
          if (imem_addr[1:0] != 2'b00) begin
            a_state_d = S_DONE;
            i_ready_d = 1'b1;
            i_exc_d   = 1'b1;
            i_src_d   = ECODE_INST_ADDR_MISALIGNED;
          end else if (out_of_range(imem_addr)) begin
            a_state_d = S_DONE;
            i_ready_d = 1'b1;
            i_exc_d   = 1'b1;
            i_src_d   = ECODE_INST_ADDR_FAULT;
          end else begin
            a_state_d = S_BUSY;
            a_en_d    = 1'b1;
            a_addr_d  = imem_addr[HI_LSB-1:2];
          end
        end
      end
      S_BUSY: begin
        if (amem_error || amem_ready || (a_cnt_q == CNT_LAST)) begin
          a_state_d = S_DONE;
          i_ready_d = 1'b1;
          if (!amem_error && amem_ready) begin
            i_data_d = amem_in_data;
          end else begin
            i_exc_d = 1'b1;
            i_src_d = ECODE_INST_ADDR_FAULT;
          end
        end else begin
          a_en_d  = 1'b1;
          a_cnt_d = a_cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  a_state_d = S_IDLE;
      default: a_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state_q <= S_IDLE;
      a_cnt_q   <= '0;
      a_en_q    <= 1'b0;
      a_addr_q  <= '0;
      i_data_q  <= '0;
      i_ready_q <= 1'b0;
      i_exc_q   <= 1'b0;
      i_src_q   <= '0;
    end else begin
      a_state_q <= a_state_d;
      a_cnt_q   <= a_cnt_d;
      a_en_q    <= a_en_d;
      a_addr_q  <= a_addr_d;
      i_data_q  <= i_data_d;
      i_ready_q <= i_ready_d;
      i_exc_q   <= i_exc_d;
      i_src_q   <= i_src_d;
    end
  end

  // ---------------- Port B: load/store ----------------
  state_e             b_state_q, b_state_d;
  logic [CNT_W-1:0]   b_cnt_q, b_cnt_d;
  logic               b_en_q, b_en_d;
  logic [ADDR_W-1:0]  b_addr_q, b_addr_d;
  logic [3:0]         b_we_q, b_we_d;
  logic [31:0]        b_wdata_q, b_wdata_d;
  logic               b_st_q, b_st_d;
  logic [3:0]         b_inf_q, b_inf_d;
  logic [1:0]         b_lo_q, b_lo_d;
  logic [31:0]        d_data_q, d_data_d;
  logic               d_ready_q, d_ready_d;
  logic               d_exc_q, d_exc_d;
  logic [3:0]         d_src_q, d_src_d;

  // Load/store request tracker: next state and registered outputs.
  always_comb begin
    b_state_d = b_state_q;
    b_cnt_d   = '0;
    b_en_d    = 1'b0;
    b_addr_d  = b_addr_q;
    b_we_d    = '0;
    b_wdata_d = '0;
    b_st_d    = b_st_q;
    b_inf_d   = b_inf_q;
    b_lo_d    = b_lo_q;
    d_data_d  = '0;
    d_ready_d = 1'b0;
    d_exc_d   = 1'b0;
    d_src_d   = '0;
    unique case (b_state_q)
      S_IDLE: begin
        if (dmem_en) begin
          b_st_d  = dmem_rw;
          b_inf_d = dmem_data_inf;
          b_lo_d  = dmem_addr[1:0];
          if (d_misaligned(dmem_data_inf, dmem_addr[1:0])) begin
            b_state_d = S_DONE;
            d_ready_d = 1'b1;
            d_exc_d   = 1'b1;
            d_src_d   = dmem_rw ? ECODE_STORE_AMO_ADDR_MISALIGNED : ECODE_LOAD_ADDR_MISALIGNED;
          end else if (out_of_range(dmem_addr)) begin
            b_state_d = S_DONE;
            d_ready_d = 1'b1;
            d_exc_d   = 1'b1;
            d_src_d   = dmem_rw ? ECODE_STORE_AMO_ACCESS_FAULT : ECODE_LOAD_ACCESS_FAULT;
          end else begin
            b_state_d = S_BUSY;
            b_en_d    = 1'b1;
            b_addr_d  = dmem_addr[HI_LSB-1:2];
            if (dmem_rw) begin
              b_we_d    = store_we(dmem_data_inf, dmem_addr[1:0]);
              b_wdata_d = store_lanes(dmem_data_inf, dmem_out_data);
            end
          end
        end
      end
      S_BUSY: begin
        if (bmem_error || bmem_ready || (b_cnt_q == CNT_LAST)) begin
          b_state_d = S_DONE;
          d_ready_d = 1'b1;
          if (!bmem_error && bmem_ready) begin
            d_data_d = b_st_q ? 32'd0 : load_extract(bmem_in_data, b_lo_q, b_inf_q);
          end else begin
            d_exc_d = 1'b1;
            d_src_d = b_st_q ? ECODE_STORE_AMO_ACCESS_FAULT : ECODE_LOAD_ACCESS_FAULT;
          end
        end else begin
          b_en_d    = 1'b1;
          b_we_d    = b_we_q;
          b_wdata_d = b_wdata_q;
          b_cnt_d   = b_cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  b_state_d = S_IDLE;
      default: b_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state_q <= S_IDLE;
      b_cnt_q   <= '0;
      b_en_q    <= 1'b0;
      b_addr_q  <= '0;
      b_we_q    <= '0;
      b_wdata_q <= '0;
      b_st_q    <= 1'b0;
      b_inf_q   <= '0;
      b_lo_q    <= '0;
      d_data_q  <= '0;
      d_ready_q <= 1'b0;
      d_exc_q   <= 1'b0;
      d_src_q   <= '0;
    end else begin
      b_state_q <= b_state_d;
      b_cnt_q   <= b_cnt_d;
      b_en_q    <= b_en_d;
      b_addr_q  <= b_addr_d;
      b_we_q    <= b_we_d;
      b_wdata_q <= b_wdata_d;
      b_st_q    <= b_st_d;
      b_inf_q   <= b_inf_d;
      b_lo_q    <= b_lo_d;
      d_data_q  <= d_data_d;
      d_ready_q <= d_ready_d;
      d_exc_q   <= d_exc_d;
      d_src_q   <= d_src_d;
    end
  end

  assign imem_in_data    = i_data_q;
  assign imem_ready      = i_ready_q;
  assign imem_except     = i_exc_q;
  assign imem_except_src = i_src_q;
  assign amem_en         = a_en_q;
  assign amem_addr       = a_addr_q;

  assign dmem_in_data    = d_data_q;
  assign dmem_ready      = d_ready_q;
  assign dmem_except     = d_exc_q;
  assign dmem_except_src = d_src_q;
  assign bmem_en         = b_en_q;
  assign bmem_addr       = b_addr_q;
  assign bmem_rw         = b_we_q;
  assign bmem_out_data   = b_wdata_q;

endmodule

// File: tb/tb_elbeth_memory_bridge_pipe.sv
// Self-checking bench for elbeth_memory_bridge_pipe: directed corner cases plus randomized
// fetch/load/store traffic compared against a byte-level reference memory model.
module tb_elbeth_memory_bridge_pipe;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned WORDS   = 1 << ADDR_W;

  logic              clk, rst_n;
  logic              imem_en;
  logic [31:0]       imem_addr, imem_in_data;
  logic              imem_ready, imem_except;
  logic [3:0]        imem_except_src;
  logic              dmem_en, dmem_rw;
  logic [3:0]        dmem_data_inf;
  logic [31:0]       dmem_addr, dmem_out_data, dmem_in_data;
  logic              dmem_ready, dmem_except;
  logic [3:0]        dmem_except_src;
  logic              amem_en;
  logic [ADDR_W-1:0] amem_addr;
  logic [31:0]       amem_in_data;
  logic              amem_ready, amem_error;
  logic              bmem_en;
  logic [ADDR_W-1:0] bmem_addr;
  logic [3:0]        bmem_rw;
  logic [31:0]       bmem_out_data, bmem_in_data;
  logic              bmem_ready, bmem_error;

  elbeth_memory_bridge_pipe #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_in_data(imem_in_data),
    .imem_ready(imem_ready), .imem_except(imem_except), .imem_except_src(imem_except_src),
    .dmem_en(dmem_en), .dmem_rw(dmem_rw), .dmem_data_inf(dmem_data_inf), .dmem_addr(dmem_addr),
    .dmem_out_data(dmem_out_data), .dmem_in_data(dmem_in_data), .dmem_ready(dmem_ready),
    .dmem_except(dmem_except), .dmem_except_src(dmem_except_src),
    .amem_en(amem_en), .amem_addr(amem_addr), .amem_in_data(amem_in_data),
    .amem_ready(amem_ready), .amem_error(amem_error),
    .bmem_en(bmem_en), .bmem_addr(bmem_addr), .bmem_rw(bmem_rw), .bmem_out_data(bmem_out_data),
    .bmem_in_data(bmem_in_data), .bmem_ready(bmem_ready), .bmem_error(bmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory-side behaviour knobs (latency in cycles of *mem_en before ready).
  int a_lat = 0, b_lat = 0;
  bit a_hang = 0, b_hang = 0, a_err = 0, b_err = 0;

  logic [31:0] wmem [WORDS];      // word memory seen by the bridge
  logic [7:0]  rmem [4*WORDS];    // byte-level reference memory
  bit          mem_init = 0;
  int          a_cnt = 0, b_cnt = 0;

  function automatic logic [31:0] hash(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory B responder: owns wmem, applies byte-enabled stores when it answers.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int w = 0; w < int'(WORDS); w++) wmem[w] = hash(w);
      mem_init = 1;
    end
    if (bmem_en) begin
      bmem_error = b_err;
      if (!b_hang && b_cnt == b_lat) begin
        bmem_ready   = 1'b1;
        bmem_in_data = wmem[bmem_addr];
        for (int i = 0; i < 4; i++)
          if (bmem_rw[i]) wmem[bmem_addr][8*i +: 8] = bmem_out_data[8*i +: 8];
      end else begin
        bmem_ready   = 1'b0;
        bmem_in_data = $urandom;
      end
      b_cnt++;
    end else begin
      b_cnt = 0; bmem_ready = 1'b0; bmem_error = 1'b0; bmem_in_data = $urandom;
    end
  end

  // Memory A responder (read only).
  always @(negedge clk) begin
    if (amem_en) begin
      amem_error = a_err;
      if (!a_hang && a_cnt == a_lat) begin
        amem_ready = 1'b1; amem_in_data = wmem[amem_addr];
      end else begin
        amem_ready = 1'b0; amem_in_data = $urandom;
      end
      a_cnt++;
    end else begin
      a_cnt = 0; amem_ready = 1'b0; amem_error = 1'b0; amem_in_data = $urandom;
    end
  end

  // Reference model for one data access; updates rmem for completed stores.
  function automatic void ref_d(input logic rw, input logic [3:0] inf, input logic [31:0] addr,
                                input logic [31:0] sdata, input bit hang, input bit err, input int lat_cfg,
                                output logic [31:0] e_data, output logic e_exc, output logic [3:0] e_src,
                                output int e_lat, output int e_bcyc, output logic [3:0] e_we,
                                output logic [31:0] e_out);
    int sz;
    logic [31:0] v;
    sz = inf[0] ? 1 : (inf[1] ? 2 : 4);
    e_data = 0; e_exc = 0; e_src = 0; e_lat = 1; e_bcyc = 0; e_we = 0; e_out = 0;
    if ((int'(addr[1:0]) % sz) != 0) begin
      e_exc = 1; e_src = rw ? 4'd6 : 4'd4;
    end else if (addr >= 32'(4 * WORDS)) begin
      e_exc = 1; e_src = rw ? 4'd7 : 4'd5;
    end else begin
      if (rw) begin
        e_we = 4'(((1 << sz) - 1) << addr[1:0]);
        for (int i = 0; i < 4; i++) e_out[8*i +: 8] = sdata[8*(i % sz) +: 8];
      end
      if (err) begin
        e_exc = 1; e_src = rw ? 4'd7 : 4'd5; e_lat = 2; e_bcyc = 1;
      end else if (hang) begin
        e_exc = 1; e_src = rw ? 4'd7 : 4'd5; e_lat = 1 + TIMEOUT; e_bcyc = TIMEOUT;
      end else begin
        e_lat = 2 + lat_cfg; e_bcyc = lat_cfg + 1;
        if (rw) begin
          for (int i = 0; i < sz; i++) rmem[int'(addr[15:0]) + i] = sdata[8*i +: 8];
        end else begin
          v = 0;
          for (int i = 0; i < sz; i++) v = v | (32'(rmem[int'(addr[15:0]) + i]) << (8*i));
          if (inf[3] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
          e_data = v;
        end
      end
    end
  endfunction

  task automatic do_d(input logic rw, input logic [3:0] inf, input logic [31:0] addr,
                      input logic [31:0] sdata, input bit hold, input bit drop,
                      output logic [31:0] rdata, output logic exc, output logic [3:0] src,
                      output int lat, output int bcyc, output logic [ADDR_W-1:0] baddr,
                      output logic [3:0] bwe, output logic [31:0] bout);
    bit got = 0;
    @(negedge clk);
    dmem_en = 1'b1; dmem_rw = rw; dmem_data_inf = inf; dmem_addr = addr; dmem_out_data = sdata;
    lat = 0; bcyc = 0; baddr = '0; bwe = '0; bout = '0; rdata = '0; exc = 1'b0; src = '0;
    while (lat < 100) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (drop && lat == 1) dmem_en = 1'b0;
      if (bmem_en) begin
        if (bcyc == 0) begin baddr = bmem_addr; bwe = bmem_rw; bout = bmem_out_data; end
        bcyc++;
      end
      if (dmem_ready) begin
        rdata = dmem_in_data; exc = dmem_except; src = dmem_except_src; got = 1;
        break;
      end
    end
    if (!got) check("d_no_response", 32'd0, 32'd1);
    if (hold) @(negedge clk);
    dmem_en = 1'b0;
  endtask

  task automatic run_d(input string tag, input logic rw, input logic [3:0] inf, input logic [31:0] addr,
                       input logic [31:0] sdata, input bit hold, input bit drop,
                       output logic [31:0] rdata, output logic [3:0] bwe, output logic [31:0] bout,
                       output int lat, output int bcyc);
    logic [31:0] e_data, e_out;
    logic e_exc, exc;
    logic [3:0] e_src, src, e_we;
    int e_lat, e_bcyc;
    logic [ADDR_W-1:0] baddr;
    ref_d(rw, inf, addr, sdata, b_hang, b_err, b_lat, e_data, e_exc, e_src, e_lat, e_bcyc, e_we, e_out);
    do_d(rw, inf, addr, sdata, hold, drop, rdata, exc, src, lat, bcyc, baddr, bwe, bout);
    check({tag, "_data"}, rdata, e_data);
    check({tag, "_exc"}, 32'(exc), 32'(e_exc));
    check({tag, "_src"}, 32'(src), 32'(e_src));
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_bcyc"}, 32'(bcyc), 32'(e_bcyc));
    if (e_bcyc > 0) begin
      check({tag, "_baddr"}, 32'(baddr), 32'(addr[15:2]));
      check({tag, "_bwe"}, 32'(bwe), 32'(e_we));
      check({tag, "_bout"}, bout, e_out);
    end
  endtask

  task automatic run_i(input string tag, input logic [31:0] addr, output int acyc);
    logic [31:0] e_data, rdata;
    logic e_exc, exc;
    logic [3:0] e_src, src;
    int e_lat, e_acyc, lat;
    logic [ADDR_W-1:0] aaddr;
    bit got;
    e_data = 0; e_exc = 0; e_src = 0; e_lat = 1; e_acyc = 0;
    if (addr[1:0] != 2'b00) begin e_exc = 1; e_src = 4'd0; end
    else if (addr >= 32'(4 * WORDS)) begin e_exc = 1; e_src = 4'd1; end
    else if (a_err) begin e_exc = 1; e_src = 4'd1; e_lat = 2; e_acyc = 1; end
    else if (a_hang) begin e_exc = 1; e_src = 4'd1; e_lat = 1 + TIMEOUT; e_acyc = TIMEOUT; end
    else begin
      e_lat = 2 + a_lat; e_acyc = a_lat + 1;
      for (int i = 0; i < 4; i++) e_data[8*i +: 8] = rmem[int'(addr[15:0]) + i];
    end
    @(negedge clk);
    imem_en = 1'b1; imem_addr = addr;
    lat = 0; acyc = 0; aaddr = '0; rdata = '0; exc = 1'b0; src = '0; got = 0;
    while (lat < 100) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (amem_en) begin
        if (acyc == 0) aaddr = amem_addr;
        acyc++;
      end
      if (imem_ready) begin
        rdata = imem_in_data; exc = imem_except; src = imem_except_src; got = 1;
        break;
      end
    end
    if (!got) check("i_no_response", 32'd0, 32'd1);
    imem_en = 1'b0;
    check({tag, "_data"}, rdata, e_data);
    check({tag, "_exc"}, 32'(exc), 32'(e_exc));
    check({tag, "_src"}, 32'(src), 32'(e_src));
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_acyc"}, 32'(acyc), 32'(e_acyc));
    if (e_acyc > 0) check({tag, "_aaddr"}, 32'(aaddr), 32'(addr[15:2]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, bo;
    logic [3:0] we;
    int lat, cyc, lat2, cyc2, r, sel;
    logic [31:0] addr;
    logic [3:0] inf;

    for (int w = 0; w < int'(WORDS); w++)
      for (int i = 0; i < 4; i++) rmem[4*w + i] = hash(w) >> (8*i);

    rst_n = 1'b0; imem_en = 0; imem_addr = 0;
    dmem_en = 0; dmem_rw = 0; dmem_data_inf = 0; dmem_addr = 0; dmem_out_data = 0;
    #12;
    check("rst_b_port", {bmem_en, bmem_rw, bmem_out_data[15:0], 2'b00, bmem_addr}, 32'd0);
    check("rst_d_port", {dmem_ready, dmem_except, dmem_except_src}, 32'd0);
    check("rst_d_data", dmem_in_data, 32'd0);
    check("rst_a_port", {amem_en, imem_ready, imem_except, imem_except_src, 2'b00, amem_addr}, 32'd0);
    check("rst_i_data", imem_in_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // LW at 0x40 with minimum memory latency
    run_d("lw40", 1'b0, 4'b0100, 32'h40, 32'h0, 0, 0, rd, we, bo, lat, cyc);
    check("lw40_min_lat", 32'(lat), 32'd2);
    // SB 0x80 at 0x43, then signed LB
    run_d("sb43", 1'b1, 4'b0001, 32'h43, 32'h0000_0080, 0, 0, rd, we, bo, lat, cyc);
    check("sb43_we", 32'(we), 32'h8);
    run_d("lb43", 1'b0, 4'b1001, 32'h43, 32'h0, 0, 0, rd, we, bo, lat, cyc);
    check("lb43_sext", rd, 32'hFFFF_FF80);
    // SH 0xBEEF at 0x42, LHU reads it back zero-extended
    run_d("sh42", 1'b1, 4'b0010, 32'h42, 32'h1234_BEEF, 0, 0, rd, we, bo, lat, cyc);
    check("sh42_we", 32'(we), 32'hC);
    check("sh42_out", bo, 32'hBEEF_BEEF);
    run_d("lhu42", 1'b0, 4'b0010, 32'h42, 32'h0, 0, 0, rd, we, bo, lat, cyc);
    check("lhu42_val", rd, 32'h0000_BEEF);
    // Misaligned store never reaches memory
    run_d("sw41", 1'b1, 4'b0100, 32'h41, 32'hDEAD_BEEF, 0, 0, rd, we, bo, lat, cyc);
    check("sw41_nomem", 32'(cyc), 32'd0);
    // Out-of-range fetch
    run_i("if_oor", 32'h0001_0000, cyc);
    check("if_oor_nomem", 32'(cyc), 32'd0);
    run_i("if_ok", 32'h44, cyc);
    // Hung memory times out after TIMEOUT cycles of bmem_en
    b_hang = 1;
    run_d("lw_to", 1'b0, 4'b0100, 32'h80, 32'h0, 0, 0, rd, we, bo, lat, cyc);
    check("lw_to_cycles", 32'(cyc), 32'(TIMEOUT));
    b_hang = 0;
    // Error and ready together: error wins
    b_err = 1; b_lat = 0;
    run_d("lw_err", 1'b0, 4'b0100, 32'h84, 32'h0, 0, 0, rd, we, bo, lat, cyc);
    b_err = 0;
    // en held through the DONE cycle is not a new request
    run_d("hold", 1'b0, 4'b0100, 32'h88, 32'h0, 1, 0, rd, we, bo, lat, cyc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_no_req", {30'd0, bmem_en, dmem_ready}, 32'd0);
    end
    // en dropped in BUSY still completes
    b_lat = 2;
    run_d("drop", 1'b0, 4'b0100, 32'h8C, 32'h0, 0, 1, rd, we, bo, lat, cyc);
    b_lat = 0;
    // Fetch and load in parallel
    a_lat = 2; b_lat = 0;
    fork
      run_i("par_if", 32'h20, cyc2);
      run_d("par_lw", 1'b0, 4'b0100, 32'h60, 32'h0, 0, 0, rd, we, bo, lat2, cyc);
    join
    a_lat = 0;
    // Async reset mid-BUSY abandons the access
    b_hang = 1;
    @(negedge clk);
    dmem_en = 1'b1; dmem_rw = 1'b0; dmem_data_inf = 4'b0100; dmem_addr = 32'h40;
    repeat (3) @(posedge clk);
    #2;
    check("rst_pre_busy", 32'(bmem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_bmem_en", 32'(bmem_en), 32'd0);
    check("rst_mid_dmem_ready", 32'(dmem_ready), 32'd0);
    @(negedge clk); dmem_en = 1'b0; b_hang = 0;
    @(negedge clk); rst_n = 1'b1;
    run_d("post_rst", 1'b0, 4'b0100, 32'h40, 32'h0, 0, 0, rd, we, bo, lat, cyc);

    // Randomized load/store traffic
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 2);
      inf = 4'(1 << sel);
      if (sel < 2) inf[3] = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      if (r == 0) addr = 32'h0001_0000 + 32'($urandom_range(0, 255));
      else addr = 32'($urandom_range(0, 31) * 4 + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0));
      b_lat  = $urandom_range(0, 3);
      b_err  = ($urandom_range(0, 19) == 0);
      b_hang = b_err || ($urandom_range(0, 24) == 0);
      run_d("rnd_d", 1'($urandom_range(0, 1)), inf, addr, $urandom, 0, 0, rd, we, bo, lat, cyc);
    end
    b_err = 0; b_hang = 0;

    // Randomized fetches over the same memory
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) addr = 32'h0001_0000 + 32'($urandom_range(0, 63) * 4);
      else addr = 32'($urandom_range(0, 63) * 4 + (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0));
      a_lat  = $urandom_range(0, 3);
      a_err  = ($urandom_range(0, 19) == 0);
      a_hang = a_err || ($urandom_range(0, 24) == 0);
      run_i("rnd_i", addr, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
